// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes ALUOp/funct3/funct7 to an ALU code and issues it to EX
// through a registered head stage backed by one skid entry.
module alu_ctrl_issue #(
   parameter int XLEN      = 32,
   parameter int TAG_W     = 5,
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           alu_op,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   input  logic [XLEN-1:0]      op_a,
   input  logic [XLEN-1:0]      op_b,
   input  logic [TAG_W-1:0]     tag_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0]           alu_ctrl,
   output logic [XLEN-1:0]      alu_a,
   output logic [XLEN-1:0]      alu_b,
   output logic [TAG_W-1:0]     tag_out,
   output logic                 illegal,
   output logic [ILL_CNT_W-1:0] ill_count
);
   localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011;
   localparam logic [3:0] C_SLL = 4'b0100, C_SRL = 4'b0101, C_SUB = 4'b0110, C_SRA = 4'b0111;
   typedef struct packed {
      logic [3:0]       ctrl;
      logic             ill;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [TAG_W-1:0] tag;
   } ent_t;
   ent_t head_q, head_d, skid_q, skid_d, in_e;
   logic head_v_q, head_v_d, skid_v_q, skid_v_d;
   logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
   logic [3:0] dec_ctrl;
   logic dec_ill, f7z, f7s, imm, acc, pop;
   always_comb begin
      f7z = funct7 == 7'h00;
      f7s = funct7 == 7'h20;
      imm = alu_op[0];
      dec_ctrl = C_ADD;
      dec_ill = 1'b0;
      case (alu_op)
         2'b00: dec_ctrl = C_ADD;
         2'b01: dec_ctrl = C_SUB;
         default: case (funct3)
            3'b000: begin
               dec_ctrl = (imm || f7z) ? C_ADD : C_SUB;
               dec_ill = !imm && !f7z && !f7s;
            end
            3'b001: begin
               dec_ctrl = C_SLL;
               dec_ill = !f7z;
            end
            3'b100: begin
               dec_ctrl = C_XOR;
               dec_ill = !imm && !f7z;
            end
            3'b101: begin
               dec_ctrl = f7s ? C_SRA : C_SRL;
               dec_ill = !f7z && !f7s;
            end
            3'b110: begin
               dec_ctrl = C_OR;
               dec_ill = !imm && !f7z;
            end
            3'b111: begin
               dec_ctrl = C_AND;
               dec_ill = !imm && !f7z;
            end
            default: dec_ill = 1'b1;
         endcase
      endcase
      in_e = '{ctrl: dec_ill ? 4'b0000 : dec_ctrl, ill: dec_ill, a: op_a, b: op_b, tag: tag_in};
   end
   // skid only fills while the head is held, so FIFO order is preserved
   always_comb begin
      acc = in_valid && !skid_v_q;
      pop = head_v_q && out_ready;
      head_d = head_q;
      skid_d = skid_q;
      head_v_d = head_v_q;
      skid_v_d = skid_v_q;
      if (flush) begin
         head_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (skid_v_q) begin
         if (pop) begin
            head_d = skid_q;
            skid_v_d = 1'b0;
         end
      end else if (acc && (!head_v_q || pop)) begin
         head_d = in_e;
         head_v_d = 1'b1;
      end else if (acc) begin
         skid_d = in_e;
         skid_v_d = 1'b1;
      end else if (pop) begin
         head_v_d = 1'b0;
      end
      ill_cnt_d = (acc && !flush && dec_ill && !(&ill_cnt_q)) ? ill_cnt_q + ILL_CNT_W'(1) : ill_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         skid_q <= '0;
         head_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         ill_cnt_q <= '0;
      end else begin
         head_q <= head_d;
         skid_q <= skid_d;
         head_v_q <= head_v_d;
         skid_v_q <= skid_v_d;
         ill_cnt_q <= ill_cnt_d;
      end
   end
   assign in_ready = !skid_v_q;
   assign out_valid = head_v_q;
   assign alu_ctrl = head_q.ctrl;
   assign illegal = head_q.ill;
   assign alu_a = head_q.a;
   assign alu_b = head_q.b;
   assign tag_out = head_q.tag;
   assign ill_count = ill_cnt_q;
endmodule
